// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-file responder running on the system clock.
// Optional burst addressing enabled by defining SPI_REG_AUTO_INC_EN.
module spi_reg_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 8,
    localparam int ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  SCLK,
    input  logic                  SIMO,
    output logic                  SOMI,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wr_strobe,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  frame_err
);
    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        ST_WAIT_CS_HIGH,
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  cs_s1_q, cs_s2_q;
    logic                  sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic                  simo_s1_q, simo_s2_q;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_in_q, shift_in_d;
    logic [DATA_WIDTH-1:0] shift_out_q, shift_out_d;
    logic                  rw_q, rw_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  preload_q, preload_d;
    logic                  somi_q, somi_d;
    logic                  wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic                  frame_err_q, frame_err_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  we;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic sclk_rise, sclk_fall, last_bit;
    assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
    assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
    assign last_bit  = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        preload_d   = preload_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        we          = 1'b0;

        case (state_q)
            ST_WAIT_CS_HIGH: if (cs_s2_q) state_d = ST_IDLE;
            ST_IDLE: begin
                if (!cs_s2_q) begin
                    state_d     = ST_CMD;
                    bit_cnt_d   = '0;
                    shift_out_d = '0;
                    preload_d   = 1'b0;
                end
            end
            ST_CMD: begin
                if (cs_s2_q) begin
                    state_d     = ST_IDLE;
                    frame_err_d = (bit_cnt_q != '0);
                end else if (sclk_rise) begin
                    shift_in_d = {shift_in_q[DATA_WIDTH-2:0], simo_s2_q};
                    if (last_bit) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        rw_d      = shift_in_d[DATA_WIDTH-1];
                        addr_d    = shift_in_d[ADDR_W-1:0];
                        preload_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (cs_s2_q) begin
                    state_d     = ST_IDLE;
                    frame_err_d = (bit_cnt_q != '0);
                end else if (sclk_rise) begin
                    shift_in_d = {shift_in_q[DATA_WIDTH-2:0], simo_s2_q};
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            we          = 1'b1;
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = addr_q;
                            wr_data_d   = shift_in_d;
                        end
`ifdef SPI_REG_AUTO_INC_EN
                        addr_d    = addr_q + ADDR_W'(1);
                        preload_d = 1'b1;
`else
                        state_d   = ST_DONE;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall && !rw_q) begin
                    // First falling edge of each byte presents the new register's MSB
                    if (preload_q) begin
                        shift_out_d = regs_q[addr_q];
                        preload_d   = 1'b0;
                    end else begin
                        shift_out_d = {shift_out_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            ST_DONE: if (cs_s2_q) state_d = ST_IDLE;
            default: state_d = ST_WAIT_CS_HIGH;
        endcase

        somi_d = (state_d == ST_DATA) && !rw_d && shift_out_d[DATA_WIDTH-1];
        busy_d = !cs_s2_q && (state_q != ST_WAIT_CS_HIGH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT_CS_HIGH;
            cs_s1_q     <= 1'b0;
            cs_s2_q     <= 1'b0;
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_s3_q   <= 1'b0;
            simo_s1_q   <= 1'b0;
            simo_s2_q   <= 1'b0;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            preload_q   <= 1'b0;
            somi_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            rd_data_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cs_s1_q     <= cs;
            cs_s2_q     <= cs_s1_q;
            sclk_s1_q   <= SCLK;
            sclk_s2_q   <= sclk_s1_q;
            sclk_s3_q   <= sclk_s2_q;
            simo_s1_q   <= SIMO;
            simo_s2_q   <= simo_s1_q;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            preload_q   <= preload_d;
            somi_q      <= somi_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            rd_data_q   <= regs_q[rd_addr];
            if (we) regs_q[addr_q] <= wr_data_d;
        end
    end

    assign SOMI      = somi_q;
    assign rd_data   = rd_data_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
endmodule
